serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand, difference and bit-counter width.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1: request to begin a subtraction; sampled each edge.
REQ-005 SHALL have port a  input  WIDTH: minuend, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH: subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port bin  input  1: borrow-in, sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1: high while bits are being processed.
REQ-009 SHALL have port done  output  1: one-cycle pulse marking that a result is complete.
REQ-010 SHALL have port diff  output  WIDTH: registered result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1: registered borrow-out of the final bit.
REQ-012 SHALL have port flags  output  4: registered {N,Z,C,V} for the last result.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it latches a, b and bin, clears the bit counter and enters SHIFT.
REQ-015 SHALL ignore start while in SHIFT; the latched operands and the counter are unaffected.
REQ-016 SHALL process exactly one bit per SHIFT cycle, LSB first, using a single full-subtractor cell with a borrow register.
REQ-017 Full-subtractor cell: d = a^b^br; next br = (~a&b) | (~a&br) | (b&br); br is initialised to the latched bin.
REQ-018 SHALL shift each difference bit into the MSB of the result shift register, so that after WIDTH shifts diff[0] holds bit 0.
REQ-019 SHALL leave SHIFT after WIDTH cycles (counter = WIDTH-1 on the last one), then enter DONE for exactly one cycle.
REQ-020 Timing: if start is accepted at edge T, busy is high for cycles T+1 through T+WIDTH, and done is high in cycle T+WIDTH+1.
REQ-021 SHALL update diff, bout and flags on the edge that enters DONE, and hold them until the next completion or reset.
REQ-022 DONE transitions to SHIFT if start is high; otherwise it transitions to IDLE.
REQ-023 Back-to-back operation from DONE SHALL NOT add an idle cycle; done pulses again WIDTH+1 cycles later.
REQ-024 busy and done SHALL never be high at the same time.

Reset
REQ-025 When reset is high at an edge, the block SHALL enter IDLE with busy=0, done=0, diff=0, bout=0, flags=0, counter=0 and borrow register=0.
REQ-026 Reset SHALL take priority over start, including when both are high on the same edge.
REQ-027 Reset during SHIFT SHALL abort the operation, with no done pulse for it.

Configuration
REQ-028 Macro SERIAL_SUBTRACTOR_FLAGS_EN, when defined, SHALL compute flags as follows:
- N = diff[WIDTH-1]
- Z = (diff == 0)
- C = ~bout
- V = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the latched operands
REQ-029 When SERIAL_SUBTRACTOR_FLAGS_EN is undefined, the flags port SHALL remain present, be tied to 4'b0000 and use no flag logic.

Verification
REQ-030 a=0x0005, b=0x0003, bin=0 -> done at T+17, diff=0x0002, bout=0, flags=4'b0010.
REQ-031 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, flags=4'b1000.
REQ-032 a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, flags=4'b0011 (signed overflow).
REQ-033 a=0x1234, b=0x1233, bin=1 -> diff=0x0000, bout=0, flags=4'b0110; in the same test, start is held high in DONE -> next done pulses 17 cycles later.
REQ-034 Start pulses during SHIFT with different operands -> the result is unchanged; reset raised at the 8th SHIFT cycle -> next cycle all outputs are 0, state is IDLE, and no done pulse follows.
REQ-035 Build without SERIAL_SUBTRACTOR_FLAGS_EN and rerun REQ-030..REQ-033 -> diff and bout are identical, flags=4'b0000 throughout.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell computes a - b - bin, LSB first.
// Optional macro SERIAL_SUBTRACTOR_FLAGS_EN enables {N,Z,C,V}; otherwise flags read 4'b0000.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [3:0]       flags
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] cnt;
  logic             br;
  logic             d_bit;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] res_next;

  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
  assign res_next = {d_bit, res[WIDTH-1:1]};
  assign last     = (cnt == WIDTH'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Any state other than SHIFT may accept a new operation, so DONE chains
  // straight into the next SHIFT without an idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= res_next;
          cnt  <= cnt + WIDTH'(1);
          if (last) begin
            state <= DONE;
            diff  <= res_next;
            bout  <= br_next;
          end
        end
        default: begin
          if (start) begin
            state <= SHIFT;
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic       a_msb;
  logic       b_msb;
  logic [3:0] flags_r;

  // Operand sign bits are kept separately since the shift registers lose them.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      flags_r <= 4'b0000;
    end else begin
      if (state != SHIFT && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == SHIFT && last) begin
        flags_r <= {res_next[WIDTH-1],
                    (res_next == '0),
                    ~br_next,
                    (a_msb ^ b_msb) & (a_msb ^ res_next[WIDTH-1])};
      end
    end
  end

  assign flags = flags_r;
`else
  assign flags = 4'b0000;
`endif

endmodule
